// File: rtl/sd_pkg.sv
// Shared types and constants for the event counter and its display.
// Optional stretcher enable macro: SD_EVT_STRETCH_EN.
package sd_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } stretch_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/sd_seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-BCD codes blank the digit.
module sd_seg7_dec
    import sd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [6:0]       o_seg
);

    // Map one BCD digit to its segment pattern
    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sd_event_counter.sv
// Two-digit BCD detection counter with LED stretcher and muxed display.
// Define SD_EVT_STRETCH_EN to enable the LED hold FSM.
module sd_event_counter
    import sd_pkg::*;
#(
    parameter int STRETCH_CYC = 8,
    parameter int SCAN_DIV    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det,
    input  logic [3:0] det_led,
    input  logic       clr,
    output logic [7:0] count_bcd,
    output logic       ovf,
    output logic [3:0] led,
    output logic [6:0] seg,
    output logic [1:0] an
);

    if (STRETCH_CYC < 1 || STRETCH_CYC > 255) begin : g_bad_stretch
        $error("STRETCH_CYC out of range 1..255");
    end
    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan
        $error("SCAN_DIV out of range 2..65535");
    end

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    logic [BCD_W-1:0] r_ones;
    logic [BCD_W-1:0] r_tens;
    logic             r_ovf;
    logic [3:0]       r_led;
    logic [15:0]      r_scan_cnt;
    logic             r_sel;
    logic [1:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_scan_wrap;
    logic             w_sel_nxt;
    logic [BCD_W-1:0] w_digit;
    logic [6:0]       w_seg;

    // BCD event count; clear wins and swallows a coincident detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ones <= '0;
            r_tens <= '0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_ones <= '0;
            r_tens <= '0;
            r_ovf  <= 1'b0;
        end else if (det) begin
            if (r_ones == BCD_MAX) begin
                r_ones <= '0;
                if (r_tens == BCD_MAX) begin
                    r_tens <= '0;
                    r_ovf  <= 1'b1;
                end else begin
                    r_tens <= r_tens + 1'b1;
                end
            end else begin
                r_ones <= r_ones + 1'b1;
            end
        end
    end

`ifdef SD_EVT_STRETCH_EN
    localparam logic [7:0] HOLD_LOAD = 8'(STRETCH_CYC - 1);

    stretch_state_t r_state;
    logic [7:0]     r_hold_cnt;

    // Hold the latched pattern; any detection restarts the hold window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_led      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (det) begin
                        r_led      <= det_led;
                        r_hold_cnt <= HOLD_LOAD;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (det) begin
                        r_led      <= det_led;
                        r_hold_cnt <= HOLD_LOAD;
                    end else if (r_hold_cnt == 8'd0) begin
                        r_led   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_led   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    // Pass the pattern through for one cycle per detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= det ? det_led : 4'b0000;
        end
    end
`endif

    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
    assign w_sel_nxt   = r_sel ^ w_scan_wrap;
    assign w_digit     = w_sel_nxt ? r_tens : r_ones;

    sd_seg7_dec u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    // Digit scan: anode and segments switch together on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_sel      <= 1'b0;
            r_an       <= 2'b10;
            r_seg      <= SEG_0;
        end else begin
            r_scan_cnt <= w_scan_wrap ? 16'd0 : r_scan_cnt + 1'b1;
            r_sel      <= w_sel_nxt;
            r_an       <= w_sel_nxt ? 2'b01 : 2'b10;
            r_seg      <= w_seg;
        end
    end

    assign count_bcd = {r_tens, r_ones};
    assign ovf       = r_ovf;
    assign led       = r_led;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: tb/tb_sd_event_counter.sv
// Directed self-checking bench for sd_event_counter.
// Stretcher checks follow SD_EVT_STRETCH_EN as the DUT does.
`timescale 1ns/1ps
module tb_sd_event_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       det;
    logic [3:0] det_led;
    logic       clr;
    logic [7:0] count_bcd;
    logic       ovf;
    logic [3:0] led;
    logic [6:0] seg;
    logic [1:0] an;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sd_event_counter #(
        .STRETCH_CYC (8),
        .SCAN_DIV    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .det       (det),
        .det_led   (det_led),
        .clr       (clr),
        .count_bcd (count_bcd),
        .ovf       (ovf),
        .led       (led),
        .seg       (seg),
        .an        (an)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] pat, input int n);
        det     = 1'b1;
        det_led = pat;
        for (int i = 0; i < n; i++) tick();
        det     = 1'b0;
        det_led = 4'b0000;
    endtask

    task automatic measure_led(output int n);
        n = 0;
        while (led != 4'b0000 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic measure_an(output int n);
        logic [1:0] cur;
        cur = an;
        n = 1;
        tick();
        while (an == cur && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin : stim
        int n;
        logic [1:0] cur;
        reset   = 1'b1;
        det     = 1'b0;
        det_led = 4'b0000;
        clr     = 1'b0;
        tick();
        tick();
        chk("rst_count", count_bcd, 8'h00);
        chk("rst_ovf",   ovf,       1'b0);
        chk("rst_led",   led,       4'h0);
        chk("rst_an",    an,        2'b10);
        chk("rst_seg",   seg,       7'h40);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            pulse(4'b0001, 1);
            tick();
        end
        chk("three_count", count_bcd, 8'h03);
        chk("three_ovf",   ovf,       1'b0);

        for (int i = 0; i < 12; i++) tick();
`ifdef SD_EVT_STRETCH_EN
        pulse(4'b0110, 1);
        chk("st_led_val", led, 4'b0110);
        measure_led(n);
        chk("st_hold_len", n, 8);
        pulse(4'b0110, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("st_mid_hold", led, 4'b0110);
        pulse(4'b0110, 1);
        measure_led(n);
        chk("st_retrig_len", n, 8);
`else
        pulse(4'b0110, 1);
        chk("pt_led_val", led, 4'b0110);
        tick();
        chk("pt_led_off", led, 4'b0000);
        det = 1'b1;
        det_led = 4'b1001;
        tick();
        chk("pt_led_a", led, 4'b1001);
        det_led = 4'b0011;
        tick();
        chk("pt_led_b", led, 4'b0011);
        det = 1'b0;
        tick();
        chk("pt_led_end", led, 4'b0000);
`endif

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", count_bcd, 8'h00);
        pulse(4'b0001, 5);
        chk("five_count", count_bcd, 8'h05);
        det = 1'b1;
        clr = 1'b1;
        tick();
        det = 1'b0;
        clr = 1'b0;
        chk("clr_prio", count_bcd, 8'h00);
        tick();
        chk("clr_drop", count_bcd, 8'h00);

        pulse(4'b0001, 10);
        chk("carry_10", count_bcd, 8'h10);
        pulse(4'b0001, 89);
        chk("pre_99", count_bcd, 8'h99);
        chk("pre_99_ovf", ovf, 1'b0);
        pulse(4'b0001, 1);
        chk("wrap_count", count_bcd, 8'h00);
        chk("wrap_ovf",   ovf,       1'b1);
        pulse(4'b0001, 1);
        chk("post_count", count_bcd, 8'h01);
        chk("ovf_sticky", ovf,       1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf",   ovf,       1'b0);
        chk("clr_count2", count_bcd, 8'h00);

        pulse(4'b0001, 42);
        chk("cnt_42", count_bcd, 8'h42);
        tick();
        tick();
        measure_an(n);
        for (int k = 0; k < 3; k++) begin
            cur = an;
            if (cur == 2'b10) chk("seg_ones", seg, 7'h24);
            else chk("seg_tens", seg, 7'h19);
            chk("an_legal", (cur == 2'b10 || cur == 2'b01), 1'b1);
            measure_an(n);
            chk("scan_len", n, 4);
        end

        pulse(4'b1010, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led",   led,       4'h0);
        chk("arst_count", count_bcd, 8'h00);
        chk("arst_an",    an,        2'b10);
        chk("arst_seg",   seg,       7'h40);
        tick();
        reset = 1'b0;
        tick();
        pulse(4'b0101, 1);
        chk("post_rst_led", led,       4'b0101);
        chk("post_rst_cnt", count_bcd, 8'h01);
`ifdef SD_EVT_STRETCH_EN
        measure_led(n);
        chk("post_rst_hold", n, 8);
`else
        tick();
        chk("post_rst_off", led, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
